// File: rtl/result_serializer.sv
// result_serializer: takes a parallel word on start and sends it LSB first,
// one bit per accepted beat, then pulses done for a single cycle.
//
// Handshake: a bit moves downstream on a rising edge where serial_valid=1 and
// sink_ready=1. While serial_valid=1 and sink_ready=0, serial_out and all
// internal state hold, so the presented bit is stable for any stall length.
// serial_valid never depends on sink_ready in the same cycle.
module result_serializer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             sink_ready,
  output logic             ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done,
  output logic [2:0]       state_dbg
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // One-hot encoding: bit 0 IDLE, bit 1 SHIFT, bit 2 DONE.
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    SHIFT = 3'b010,
    DONE  = 3'b100
  } state_e;

  // State is kept as a raw vector so that non-one-hot values are visible
  // and fall through to the recovery branch below.
  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit;

  assign last_bit  = (bit_cnt == LAST_BIT);
  assign state_dbg = state_q;

  // State register; reset parks the machine in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; outputs depend only on registered values.
  always_comb begin
    state_d      = IDLE;
    ready        = 1'b0;
    serial_valid = 1'b0;
    serial_out   = 1'b0;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        ready   = 1'b1;
        state_d = start ? SHIFT : IDLE;
      end
      SHIFT: begin
        serial_valid = 1'b1;
        serial_out   = shift_reg[0];
        state_d      = (sink_ready && last_bit) ? DONE : SHIFT;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        // Zero or multiple state bits set: everything quiet, back to IDLE.
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: capture on the accepting edge, shift on each accepted bit
  // except the last one (the count exits SHIFT before it could wrap).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if ((state_q == IDLE) && start) begin
      shift_reg <= data_in;
      bit_cnt   <= '0;
    end else if ((state_q == SHIFT) && sink_ready && !last_bit) begin
      shift_reg <= shift_reg >> 1;
      bit_cnt   <= bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer with a word-level scoreboard.
module tb_result_serializer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] data_in;
  logic         sink_ready;
  logic         ready;
  logic         serial_out;
  logic         serial_valid;
  logic         done;
  logic [2:0]   state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  // Clock generation
  always #5 clk = ~clk;

  result_serializer #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .data_in      (data_in),
    .sink_ready   (sink_ready),
    .ready        (ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer. Caller has set start=1/data_in and pushed the word.
  // Sampling happens on falling edges; inputs for the next rising edge are
  // driven right after sampling.
  task automatic run_transfer(input string tag, input int stall_at, input int stall_len,
                              input int inj_bit, input bit hold, input logic [W-1:0] next_data);
    int           cyc       = 0;
    int           bit_idx   = 0;
    int           stall_cnt = 0;
    bit           injected  = 1'b0;
    bit           got_done  = 1'b0;
    logic [W-1:0] cur;
    cur = exp_q.pop_front();
    while (!got_done && cyc < W + stall_len + 4) begin
      @(negedge clk);
      cyc++;
      start = hold;
      if (hold && cyc == 1) data_in = next_data;
      check({tag, " valid"}, serial_valid, (cyc <= W + stall_len) ? 1 : 0);
      check({tag, " ready"}, ready, 0);
      check({tag, " done"}, done, (cyc == W + stall_len + 1) ? 1 : 0);
      check({tag, " state"}, state_dbg, (cyc <= W + stall_len) ? 3'b010 : 3'b100);
      if (serial_valid)
        check({tag, " bit"}, serial_out, (bit_idx < W) ? cur[bit_idx] : 1'b0);
      else
        check({tag, " out0"}, serial_out, 0);
      if (done) begin
        got_done = 1'b1;
        check({tag, " count"}, bit_idx, W);
      end
      if (inj_bit >= 0 && serial_valid && bit_idx == inj_bit && !injected) begin
        start    = 1'b1;
        data_in  = '1;
        injected = 1'b1;
      end
      if (serial_valid && bit_idx == stall_at && stall_cnt < stall_len) begin
        sink_ready = 1'b0;
        stall_cnt++;
      end else begin
        sink_ready = 1'b1;
      end
      if (serial_valid && sink_ready) bit_idx++;
    end
    if (!got_done) check({tag, " timeout"}, cyc, W + stall_len + 1);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, " idle ready"}, ready, 1);
    check({tag, " idle done"}, done, 0);
    check({tag, " idle state"}, state_dbg, 3'b001);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    sink_ready = 1'b1;
    data_in    = '0;
    repeat (2) @(negedge clk);
    check("rst ready", ready, 1);
    check("rst valid", serial_valid, 0);
    check("rst out", serial_out, 0);
    check("rst done", done, 0);
    check("rst state", state_dbg, 3'b001);
    reset = 1'b0;
    @(negedge clk);
    check("post rst ready", ready, 1);
    check("post rst valid", serial_valid, 0);

    // Basic transfer
    start = 1'b1; data_in = 16'hA5C3; exp_q.push_back(data_in);
    run_transfer("basic", -1, 0, -1, 1'b0, '0);
    check_idle("basic");

    // Back-pressure on the first bit
    start = 1'b1; data_in = 16'h0001; exp_q.push_back(data_in);
    run_transfer("stall", 0, 5, -1, 1'b0, '0);
    check_idle("stall");

    // Start during SHIFT is ignored
    start = 1'b1; data_in = 16'h0000; exp_q.push_back(data_in);
    run_transfer("ignore", -1, 0, 4, 1'b0, '0);
    check_idle("ignore");
    check_idle("ignore2");

    // Asynchronous reset while bit 7 is presented
    start = 1'b1; data_in = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre rst valid", serial_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("mid rst ready", ready, 1);
    check("mid rst valid", serial_valid, 0);
    check("mid rst done", done, 0);
    check("mid rst out", serial_out, 0);
    @(negedge clk);
    check("hold rst ready", ready, 1);
    check("hold rst done", done, 0);
    start = 1'b1; data_in = 16'h8000; reset = 1'b0; exp_q.push_back(data_in);
    run_transfer("after_rst", -1, 0, -1, 1'b0, '0);
    check_idle("after_rst");

    // Back-to-back with start held high
    start = 1'b1; data_in = 16'h1234; exp_q.push_back(data_in);
    run_transfer("b2b_a", -1, 0, -1, 1'b1, 16'h5678);
    @(negedge clk);
    check("b2b gap ready", ready, 1);
    check("b2b gap valid", serial_valid, 0);
    exp_q.push_back(data_in);
    run_transfer("b2b_b", -1, 0, -1, 1'b0, '0);
    check_idle("b2b_b");

    // Illegal state vectors recover to IDLE
    force dut.state_q = 3'b011;
    #1;
    check("bad011 valid", serial_valid, 0);
    check("bad011 done", done, 0);
    check("bad011 ready", ready, 0);
    release dut.state_q;
    check_idle("bad011");
    check_idle("bad011b");
    force dut.state_q = 3'b000;
    #1;
    check("bad000 valid", serial_valid, 0);
    check("bad000 done", done, 0);
    release dut.state_q;
    check_idle("bad000");

    check("queue empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
